// File: rtl/hazard_pkg.sv
// Shared types for the scoreboard hazard unit: controller state and stall cause.
package hazard_pkg;

  typedef enum logic [1:0] {RUN, MEM_WAIT, IF_WAIT, HALTED} hz_state_t;

  // MEM doubles as "pipeline frozen": any memory/fetch wait or halt.
  typedef enum logic [2:0] {NONE, MEM, DEP, STRUCT, CSR, FLUSH} stall_cause_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard for variable-latency results, with a short
// speculative-issue history so recently issued long ops can be squashed.
module reg_scoreboard #(
  parameter  int NREGS      = 32,
  parameter  int SPEC_DEPTH = 2,
  localparam int RW         = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_adv,
  input  logic             i_issue_long,
  input  logic [RW-1:0]    i_issue_rd,
  input  logic             i_wb_valid,
  input  logic [RW-1:0]    i_wb_rd,
  input  logic             i_squash,
  output logic [NREGS-1:0] o_busy
);

  logic [NREGS-1:0]      r_busy;
  logic [NREGS-1:0]      w_busy_nxt;
  logic [SPEC_DEPTH-1:0] r_spec_vld;
  logic [RW-1:0]         r_spec_rd [SPEC_DEPTH];
  logic                  w_push;

  assign w_push = i_issue_long && (i_issue_rd != '0);

  // Clear by writeback, clear by squash, then set by issue so a same-cycle set wins.
  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    w_busy_nxt = r_busy;
    if (i_wb_valid) w_busy_nxt[i_wb_rd] = 1'b0;
    if (i_squash) begin
      for (int i = 0; i < SPEC_DEPTH; i++)
        if (r_spec_vld[i]) w_busy_nxt[r_spec_rd[i]] = 1'b0;
    end
    if (w_push) w_busy_nxt[i_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this history is a tiny shift register, not a RAM, so resetting it is cheap and safe.
      r_busy     <= '0;
      r_spec_vld <= '0;
      for (int i = 0; i < SPEC_DEPTH; i++) r_spec_rd[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments model all flops updating together on the edge.
      r_busy <= w_busy_nxt;
      if (i_squash) begin
        r_spec_vld <= '0;
      end else if (i_adv) begin
        r_spec_vld[0] <= w_push;
        r_spec_rd[0]  <= i_issue_rd;
        for (int i = 1; i < SPEC_DEPTH; i++) begin
          r_spec_vld[i] <= r_spec_vld[i-1];
          r_spec_rd[i]  <= r_spec_rd[i-1];
        end
      end
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Parametrised pipeline hazard controller: memory-stall FSM, scoreboard dependency stalls,
// CSR drain and branch flush. Optional perf counters: define STALL_PERF_CNT_EN.
module scoreboard_hazard_unit
  import hazard_pkg::*;
#(
  parameter  int NBOUND     = 4,
  parameter  int NREGS      = 32,
  parameter  int BR_BOUND   = 2,
  parameter  int SPEC_DEPTH = 2,
  parameter  int CNT_W      = 32,
  localparam int RW         = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              dread,
  input  logic              dwrite,
  input  logic              dec_valid,
  input  logic [RW-1:0]     dec_rs1,
  input  logic [RW-1:0]     dec_rs2,
  input  logic [RW-1:0]     dec_rd,
  input  logic              dec_use_rs1,
  input  logic              dec_use_rs2,
  input  logic              dec_long,
  input  logic              dec_csr,
  input  logic              long_busy,
  input  logic              wb_valid,
  input  logic [RW-1:0]     wb_rd,
  input  logic              branch_flush,
  output logic [NBOUND-1:0] en,
  output logic [NBOUND-1:0] flush,
  output logic [NREGS-1:0]  busy_vec
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_mem,
  output logic [CNT_W-1:0]  perf_dep,
  output logic [CNT_W-1:0]  perf_csr,
  output logic [CNT_W-1:0]  perf_flush
`endif
);

  localparam logic [NBOUND-1:0] BR_MASK = NBOUND'((64'd1 << (BR_BOUND + 1)) - 64'd1);

  hz_state_t         r_state;
  stall_cause_t      w_cause;
  logic [NBOUND-2:0] r_inflight;
  logic [NREGS-1:0]  w_wb_mask, w_busy_eff;
  logic              w_mem_miss, w_dep, w_struct, w_csr, w_issue;

  assign w_mem_miss = (dread | dwrite) & ~dhit;
  assign w_wb_mask  = wb_valid ? (NREGS'(1) << wb_rd) : '0;
  assign w_busy_eff = busy_vec & ~w_wb_mask;
  assign w_dep      = dec_valid & ((dec_use_rs1 & w_busy_eff[dec_rs1]) |
                                   (dec_use_rs2 & w_busy_eff[dec_rs2]) |
                                   (dec_long & (dec_rd != '0) & w_busy_eff[dec_rd]));
  assign w_struct   = dec_valid & dec_long & long_busy;
  assign w_csr      = dec_valid & dec_csr & ((|r_inflight) | (|busy_vec));

  always_comb begin
    w_cause = NONE;
    if ((r_state != RUN) || w_mem_miss || !ihit || halt) w_cause = MEM;
    else if (branch_flush)                               w_cause = FLUSH;
    else if (w_dep)                                      w_cause = DEP;
    else if (w_struct)                                   w_cause = STRUCT;
    else if (w_csr)                                      w_cause = CSR;
  end

  // Dependency, structural and CSR stalls all hold decode and bubble execute.
  always_comb begin
    en    = '1;
    flush = '0;
    unique case (w_cause)
      MEM:             en = '0;
      FLUSH:           flush = BR_MASK;
      DEP, STRUCT, CSR: begin
        en[0]    = 1'b0;
        flush[1] = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      en    = '0;
      flush = '0;
    end
  end

  assign w_issue = en[1] & ~flush[1] & dec_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_mem_miss) r_state <= MEM_WAIT;
          else if (!ihit) r_state <= IF_WAIT;
          else if (halt)  r_state <= HALTED;
        end
        MEM_WAIT: if (dhit) r_state <= ihit ? RUN : IF_WAIT;
        IF_WAIT:  if (ihit) r_state <= RUN;
        default:  r_state <= HALTED;
      endcase
    end
  end

  // Occupancy of each boundary past decode; a flushed boundary receives a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      if (en[1]) r_inflight[0] <= w_issue;
      for (int k = 1; k < NBOUND - 1; k++)
        if (en[k+1]) r_inflight[k] <= flush[k+1] ? 1'b0 : r_inflight[k-1];
    end
  end

  reg_scoreboard #(.NREGS(NREGS), .SPEC_DEPTH(SPEC_DEPTH)) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .i_adv        (en[1]),
    .i_issue_long (w_issue & dec_long),
    .i_issue_rd   (dec_rd),
    .i_wb_valid   (wb_valid),
    .i_wb_rd      (wb_rd),
    .i_squash     (w_cause == FLUSH),
    .o_busy       (busy_vec)
  );

`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_mem   <= '0;
      perf_dep   <= '0;
      perf_csr   <= '0;
      perf_flush <= '0;
    end else begin
      if ((r_state == MEM_WAIT || r_state == IF_WAIT) && !(&perf_mem)) perf_mem <= perf_mem + 1'b1;
      if ((w_cause == DEP || w_cause == STRUCT) && !(&perf_dep))        perf_dep <= perf_dep + 1'b1;
      if (w_cause == CSR && !(&perf_csr))                                perf_csr <= perf_csr + 1'b1;
      if (w_cause == FLUSH && !(&perf_flush))                            perf_flush <= perf_flush + 1'b1;
    end
  end
`endif

endmodule
